sum_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 24-bit segmented carry-increment adder used in the FP multiplier mantissa-rounding path.
- Computes o_sum = i_data + i_carry over WIDTH bits.
- The carry ripples through NSEG = WIDTH/SEG segments, with one register stage per segment.
- Valid/ready handshake on both sides, so the block can sit between the multiplier array and the normaliser/packer.

---
 rtl/sum_pipe.sv | 125 ++++++++++++
 tb/tb_sum_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_pipe.sv
// -----------------------------------------------------------------------------
// sum_pipe -- pipelined segmented carry-increment adder
//
// Computes o_sum = i_data + i_carry over WIDTH bits. The word is split into
// NSEG = WIDTH/SEG segments; pipeline stage s (0-based) adds the incoming
// carry into segment s only and registers the carry out of that segment for
// the next stage. A result therefore appears NSEG cycles after acceptance.
//
// Parameters
//   WIDTH  operand width in bits (multiple of SEG)
//   SEG    segment width in bits (1..WIDTH)
//   NSEG   derived number of stages, WIDTH/SEG (not overridable)
//
// Ports
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_valid  operand valid             o_ready  operand accepted this cycle
//   i_data   operand (WIDTH)           i_carry  increment / carry-in
//   o_valid  result valid              i_ready  downstream takes the result
//   o_sum    result (WIDTH)            o_carry  carry out of the MSB segment
//
// Handshake: an operand is transferred when i_valid && o_ready, a result is
// transferred when o_valid && i_ready. o_ready is combinational from o_valid
// and i_ready: the whole pipeline advances when the output slot is empty or
// is being consumed, otherwise every stage holds. o_sum/o_carry are stable
// while o_valid && !i_ready. Empty slots travel like full ones.
//
// Optional build macro
//   SUM_PIPE_SAT_EN  when defined, a carry out of the final segment forces
//                    o_sum to all ones (o_carry then flags the overflow).
//                    The mux sits in front of the last stage register, so
//                    latency does not change. Undefined: the sum wraps.
// -----------------------------------------------------------------------------
module sum_pipe #(
   parameter int WIDTH = 24,
   parameter int SEG   = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_carry,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry
);

   // Guarded so a bad SEG still elaborates far enough to report the error.
   localparam int NSEG = (SEG < 1) ? 1 : (WIDTH / SEG);

   if (SEG < 1) begin : g_bad_seg
      $error("sum_pipe: SEG (%0d) must be at least 1", SEG);
   end else if ((WIDTH % SEG) != 0) begin : g_bad_width
      $error("sum_pipe: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
   end

   logic adv;

   for (genvar s = 0; s < NSEG; s++) begin : g_stage
      // Stage registers
      logic             v_q;
      logic [WIDTH-1:0] d_q;
      logic             c_q;

      // Stage inputs: the external operand for stage 0, the previous stage
      // register otherwise.
      logic             src_v;
      logic [WIDTH-1:0] src_d;
      logic             src_c;

      logic [SEG:0]     seg_sum;
      logic [WIDTH-1:0] nxt_d;
      logic             nxt_c;

      if (s == 0) begin : g_src_in
         assign src_v = i_valid;
         assign src_d = i_data;
         assign src_c = i_carry;
      end else begin : g_src_prev
         assign src_v = g_stage[s-1].v_q;
         assign src_d = g_stage[s-1].d_q;
         assign src_c = g_stage[s-1].c_q;
      end

      // Only segment s is touched here; the other segments pass through.
      // The extra MSB of seg_sum is this segment's carry out, which is 1
      // only for an all-ones segment receiving a carry.
      assign seg_sum = {1'b0, src_d[s*SEG +: SEG]} + {{SEG{1'b0}}, src_c};

      always_comb begin
         nxt_d                = src_d;
         nxt_d[s*SEG +: SEG]  = seg_sum[SEG-1:0];
         nxt_c                = seg_sum[SEG];
`ifdef SUM_PIPE_SAT_EN
         // Overflow out of the top segment clamps the whole word.
         if ((s == NSEG - 1) && seg_sum[SEG]) begin
            nxt_d = {WIDTH{1'b1}};
         end
`endif
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
            c_q <= 1'b0;
         end else if (adv) begin
            v_q <= src_v;
            d_q <= nxt_d;
            c_q <= nxt_c;
         end
      end
   end

   // Full-pipeline stall: nothing moves unless the last slot can be vacated.
   assign adv     = !g_stage[NSEG-1].v_q || i_ready;
   assign o_ready = adv;

   assign o_valid = g_stage[NSEG-1].v_q;
   assign o_sum   = g_stage[NSEG-1].d_q;
   assign o_carry = g_stage[NSEG-1].c_q;

endmodule

// File: tb/tb_sum_pipe.sv
// -----------------------------------------------------------------------------
// tb_sum_pipe -- directed self-checking bench for sum_pipe.
//
// Three instances share clock and reset:
//   dut_a  WIDTH=24 SEG=6  (4 stages, main configuration)
//   dut_b  WIDTH=32 SEG=8  (4 stages)
//   dut_c  WIDTH=8  SEG=8  (1 stage)
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (plus #1 where o_ready must settle after i_ready changes).
// -----------------------------------------------------------------------------
module tb_sum_pipe;

   logic clk;
   logic rst_n;

   // dut_a (24/6)
   logic        a_valid, a_ready, a_carry, a_ovalid, a_iready, a_ocarry;
   logic [23:0] a_data, a_sum;
   // dut_b (32/8)
   logic        b_valid, b_ready, b_carry, b_ovalid, b_iready, b_ocarry;
   logic [31:0] b_data, b_sum;
   // dut_c (8/8)
   logic        c_valid, c_ready, c_carry, c_ovalid, c_iready, c_ocarry;
   logic [7:0]  c_data, c_sum;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef SUM_PIPE_SAT_EN
   localparam logic [23:0] EXP_ONES24 = 24'hFFFFFF;
   localparam logic [7:0]  EXP_ONES8  = 8'hFF;
`else
   localparam logic [23:0] EXP_ONES24 = 24'h000000;
   localparam logic [7:0]  EXP_ONES8  = 8'h00;
`endif

   sum_pipe #(.WIDTH(24), .SEG(6)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready),
      .i_data(a_data), .i_carry(a_carry), .o_valid(a_ovalid),
      .i_ready(a_iready), .o_sum(a_sum), .o_carry(a_ocarry));

   sum_pipe #(.WIDTH(32), .SEG(8)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready),
      .i_data(b_data), .i_carry(b_carry), .o_valid(b_ovalid),
      .i_ready(b_iready), .o_sum(b_sum), .o_carry(b_ocarry));

   sum_pipe #(.WIDTH(8), .SEG(8)) dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(c_valid), .o_ready(c_ready),
      .i_data(c_data), .i_carry(c_carry), .o_valid(c_ovalid),
      .i_ready(c_iready), .o_sum(c_sum), .o_carry(c_ocarry));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   function automatic logic out_valid(input int which);
      case (which)
         0:       return a_ovalid;
         1:       return b_ovalid;
         default: return c_ovalid;
      endcase
   endfunction

   // Present one operand to the selected instance for one cycle, then count
   // falling edges until o_valid rises (bounded at 20). Returns the measured
   // latency and the output seen on that edge.
   task automatic send_one(input int which, input logic [31:0] dd,
                           input logic cc, output int lat,
                           output logic [31:0] s, output logic co);
      @(negedge clk);
      case (which)
         0: begin a_valid = 1'b1; a_data = dd[23:0]; a_carry = cc; end
         1: begin b_valid = 1'b1; b_data = dd;       b_carry = cc; end
         default: begin c_valid = 1'b1; c_data = dd[7:0]; c_carry = cc; end
      endcase
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
      lat = 1;
      while (!out_valid(which) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      case (which)
         0:       begin s = {8'h00, a_sum};  co = a_ocarry; end
         1:       begin s = b_sum;           co = b_ocarry; end
         default: begin s = {24'h0, c_sum}; co = c_ocarry; end
      endcase
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      a_valid = 0; a_data = '0; a_carry = 0; a_iready = 1;
      b_valid = 0; b_data = '0; b_carry = 0; b_iready = 1;
      c_valid = 0; c_data = '0; c_carry = 0; c_iready = 1;
      #3;
      n_checks++;
      if (a_ovalid !== 1'b0 || a_sum !== 24'h0 || a_ocarry !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b sum=%h carry=%b, want 0/000000/0",
                  a_ovalid, a_sum, a_ocarry);
      end
      n_checks++;
      if (a_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: o_ready=%b, want 1", a_ready);
      end
      n_checks++;
      if (b_ovalid !== 1'b0 || c_ovalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_other_valid: b=%b c=%b, want 0/0", b_ovalid, c_ovalid);
      end
      idle(2);
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_latency();
      int lat; logic [31:0] s; logic co;
      send_one(0, 32'h00003F, 1'b1, lat, s, co);
      n_checks++;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL latency24: got %0d cycles, want 4", lat);
      end
      n_checks++;
      if (s[23:0] !== 24'h000040 || co !== 1'b0) begin
         n_fail++;
         $display("FAIL seg_carry24: sum=%h carry=%b, want 000040/0", s[23:0], co);
      end
      idle(3);
   endtask

   task automatic test_all_ones();
      int lat; logic [31:0] s; logic co;
      send_one(0, 32'hFFFFFF, 1'b1, lat, s, co);
      n_checks++;
      if (lat !== 4 || s[23:0] !== EXP_ONES24 || co !== 1'b1) begin
         n_fail++;
         $display("FAIL all_ones24: lat=%0d sum=%h carry=%b, want 4/%h/1",
                  lat, s[23:0], co, EXP_ONES24);
      end
      idle(3);
      // Carry-in of 0 must pass the word through unchanged.
      send_one(0, 32'hFFFFFF, 1'b0, lat, s, co);
      n_checks++;
      if (s[23:0] !== 24'hFFFFFF || co !== 1'b0) begin
         n_fail++;
         $display("FAIL no_carry24: sum=%h carry=%b, want FFFFFF/0", s[23:0], co);
      end
      idle(3);
   endtask

   task automatic test_back_to_back();
      logic [23:0] din  [3] = '{24'h123456, 24'h000FFF, 24'hABCDEF};
      logic        cin  [3] = '{1'b1, 1'b1, 1'b0};
      logic [23:0] dexp [3] = '{24'h123457, 24'h001000, 24'hABCDEF};
      a_iready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_valid = 1'b1; a_data = din[i]; a_carry = cin[i];
      end
      @(negedge clk);
      a_valid = 1'b0;
      n_checks++;
      if (a_ovalid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_early: o_valid=%b one cycle early, want 0", a_ovalid);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (a_ovalid !== 1'b1 || a_sum !== dexp[i] || a_ocarry !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result%0d: valid=%b sum=%h carry=%b, want 1/%h/0",
                     i, a_ovalid, a_sum, a_ocarry, dexp[i]);
         end
      end
      @(negedge clk);
      n_checks++;
      if (a_ovalid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_tail: o_valid=%b after last result, want 0", a_ovalid);
      end
      idle(2);
   endtask

   task automatic test_backpressure();
      logic [23:0] din  [6] = '{24'h000001, 24'h00003F, 24'h000FFF,
                                24'h03FFFF, 24'h7FFFFF, 24'h555555};
      logic        cin  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [23:0] dexp [6] = '{24'h000002, 24'h000040, 24'h000FFF,
                                24'h040000, 24'h800000, 24'h555556};
      logic [24:0] exp_q[$];
      logic [24:0] exp;
      logic [23:0] held;
      int sent = 0, got = 0, stall = 0;
      bit started = 0;
      held = '0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         @(negedge clk);
         if (a_ovalid && !started) begin
            started = 1;
            stall = 3;
         end
         a_iready = (stall == 0);
         if (sent < 6) begin
            a_valid = 1'b1; a_data = din[sent]; a_carry = cin[sent];
         end else begin
            a_valid = 1'b0;
         end
         #1;
         if (stall > 0) begin
            n_checks++;
            if (a_ready !== 1'b0 || a_ovalid !== 1'b1) begin
               n_fail++;
               $display("FAIL bp_stall_ready: o_ready=%b o_valid=%b, want 0/1",
                        a_ready, a_ovalid);
            end
            if (stall == 3) begin
               held = a_sum;
            end else begin
               n_checks++;
               if (a_sum !== held) begin
                  n_fail++;
                  $display("FAIL bp_hold: o_sum=%h changed during stall, want %h",
                           a_sum, held);
               end
            end
            stall--;
         end
         if (a_valid && a_ready) begin
            exp_q.push_back({1'b0, dexp[sent]});
            sent++;
         end
         if (a_ovalid && a_iready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL bp_extra: unexpected result sum=%h", a_sum);
            end else begin
               exp = exp_q.pop_front();
               if ({a_ocarry, a_sum} !== exp) begin
                  n_fail++;
                  $display("FAIL bp_result%0d: carry/sum=%b/%h, want %b/%h",
                           got, a_ocarry, a_sum, exp[24], exp[23:0]);
               end
            end
            got++;
         end
      end
      a_valid = 1'b0; a_iready = 1'b1;
      n_checks++;
      if (got != 6 || sent != 6 || exp_q.size() != 0 || !started) begin
         n_fail++;
         $display("FAIL bp_count: sent=%0d got=%0d left=%0d stalled=%0d, want 6/6/0/1",
                  sent, got, exp_q.size(), started);
      end
      idle(6);
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] s; logic co;
      bit early = 0;
      a_iready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_valid = 1'b1; a_data = 24'h100000 + 24'(i); a_carry = 1'b1;
      end
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (a_ovalid !== 1'b1 || a_sum !== 24'h100001) begin
         n_fail++;
         $display("FAIL rstmid_pre: valid=%b sum=%h, want 1/100001", a_ovalid, a_sum);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (a_ovalid !== 1'b0 || a_sum !== 24'h0 || a_ocarry !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_flush: valid=%b sum=%h carry=%b, want 0/000000/0",
                  a_ovalid, a_sum, a_ocarry);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (a_ovalid !== 1'b0) early = 1;
      end
      n_checks++;
      if (early) begin
         n_fail++;
         $display("FAIL rstmid_ghost: o_valid rose after reset with no input, want 0");
      end
      send_one(0, 32'h00003F, 1'b1, lat, s, co);
      n_checks++;
      if (lat !== 4 || s[23:0] !== 24'h000040) begin
         n_fail++;
         $display("FAIL rstmid_restart: lat=%0d sum=%h, want 4/000040", lat, s[23:0]);
      end
      idle(3);
   endtask

   task automatic test_other_widths();
      int lat; logic [31:0] s; logic co;
      send_one(1, 32'h00FFFFFF, 1'b1, lat, s, co);
      n_checks++;
      if (lat !== 4 || s !== 32'h01000000 || co !== 1'b0) begin
         n_fail++;
         $display("FAIL w32: lat=%0d sum=%h carry=%b, want 4/01000000/0", lat, s, co);
      end
      idle(3);
      send_one(2, 32'h7F, 1'b1, lat, s, co);
      n_checks++;
      if (lat !== 1 || s[7:0] !== 8'h80 || co !== 1'b0) begin
         n_fail++;
         $display("FAIL w8_latency: lat=%0d sum=%h carry=%b, want 1/80/0", lat, s[7:0], co);
      end
      idle(2);
      send_one(2, 32'hFF, 1'b1, lat, s, co);
      n_checks++;
      if (lat !== 1 || s[7:0] !== EXP_ONES8 || co !== 1'b1) begin
         n_fail++;
         $display("FAIL w8_all_ones: lat=%0d sum=%h carry=%b, want 1/%h/1",
                  lat, s[7:0], co, EXP_ONES8);
      end
      idle(2);
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_latency();
      test_all_ones();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_other_widths();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
